// File: rtl/regbank_wr_arbiter.sv
// ---------------------------------------------------------------------------
// regbank_wr_arbiter
//
// Round-robin write arbiter and sequencer for a small bank of enable-gated
// registers. NUM_REQ requesters share the bank. Each transaction takes three
// cycles:
//   IDLE  -> pick a winner, capture its address/data, raise its grant
//   GRANT -> enable exactly one register (or none if the address is out of
//            range), bump the commit counter
//   ACK   -> raise the winner's acknowledge (and err_o for a bad address)
// A combinational read port exposes any bank entry at all times.
//
// Ports
//   clk_i      rising-edge clock
//   rst_i      asynchronous, active-high reset
//   req_i      per-requester write request (level, held until ack)
//   addr_i     packed addresses, requester k at [k*ADDR_W +: ADDR_W]
//   data_i     packed write data, requester k at [k*SIZE +: SIZE]
//   gnt_o      registered one-hot grant, high during GRANT
//   ack_o      registered one-hot acknowledge, high during ACK
//   err_o      high during ACK when the write addressed a register >= NUM_REGS
//   busy_o     high whenever the sequencer is not IDLE
//   rd_addr_i  read address
//   rd_data_o  bank[rd_addr_i], or 0 when rd_addr_i >= NUM_REGS
//   wr_cnt_o   number of committed (non-errored) writes, wraps at 16 bits
// ---------------------------------------------------------------------------
module regbank_wr_arbiter #(
  parameter int NUM_REQ  = 4,
  parameter int SIZE     = 8,
  parameter int NUM_REGS = 4,
  parameter int ADDR_W   = 2
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [NUM_REQ-1:0]        req_i,
  input  logic [NUM_REQ*ADDR_W-1:0] addr_i,
  input  logic [NUM_REQ*SIZE-1:0]   data_i,
  output logic [NUM_REQ-1:0]        gnt_o,
  output logic [NUM_REQ-1:0]        ack_o,
  output logic                      err_o,
  output logic                      busy_o,
  input  logic [ADDR_W-1:0]         rd_addr_i,
  output logic [SIZE-1:0]           rd_data_o,
  output logic [15:0]               wr_cnt_o
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef logic [PTR_W-1:0]   ptr_t;
  typedef logic [NUM_REQ-1:0] req_t;
  typedef logic [ADDR_W-1:0]  addr_t;
  typedef logic [SIZE-1:0]    data_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    ACK   = 2'd2
  } state_e;

  typedef struct packed {
    logic found;
    ptr_t idx;
  } win_t;

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  state_e        state_q,     state_d;
  ptr_t          ptr_q,       ptr_d;
  addr_t         held_addr_q, held_addr_d;
  data_t         held_data_q, held_data_d;
  req_t          gnt_q,       gnt_d;
  req_t          ack_q,       ack_d;
  logic          err_q,       err_d;
  logic [15:0]   wr_cnt_q,    wr_cnt_d;
  data_t         bank_q [NUM_REGS];
  data_t         bank_d [NUM_REGS];

  win_t                win;
  logic                addr_ok;
  logic [NUM_REGS-1:0] wr_en;

  // -------------------------------------------------------------------------
  // Round-robin search: first set request at or above ptr, wrapping around.
  // -------------------------------------------------------------------------
  function automatic win_t pick_winner(input req_t req, input ptr_t ptr);
    win_t res;
    int   cand;
    res = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = (int'(ptr) + i) % NUM_REQ;
      if (!res.found && req[cand]) begin
        res.found = 1'b1;
        res.idx   = ptr_t'(cand);
      end
    end
    return res;
  endfunction

  assign win     = pick_winner(req_i, ptr_q);
  assign addr_ok = (int'(held_addr_q) < NUM_REGS);

  // One enable per register; an out-of-range held address matches none.
  always_comb begin
    for (int r = 0; r < NUM_REGS; r++) begin
      wr_en[r] = (state_q == GRANT) && (held_addr_q == addr_t'(r));
    end
  end

  always_comb begin
    for (int r = 0; r < NUM_REGS; r++) begin
      bank_d[r] = wr_en[r] ? held_data_q : bank_q[r];
    end
  end

  // -------------------------------------------------------------------------
  // Next-state / output logic
  // -------------------------------------------------------------------------
  // NOTE: every signal gets a default before the case so no path leaves a
  // variable unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    held_addr_d = held_addr_q;
    held_data_d = held_data_q;
    gnt_d       = '0;
    ack_d       = '0;
    err_d       = 1'b0;
    wr_cnt_d    = wr_cnt_q;

    unique case (state_q)
      IDLE: begin
        if (win.found) begin
          state_d     = GRANT;
          held_addr_d = addr_i[win.idx*ADDR_W +: ADDR_W];
          held_data_d = data_i[win.idx*SIZE +: SIZE];
          gnt_d       = req_t'(1) << win.idx;
          ptr_d       = ptr_t'((int'(win.idx) + 1) % NUM_REQ);
        end
      end

      GRANT: begin
        // The register itself commits through wr_en at this same edge.
        state_d = ACK;
        ack_d   = gnt_q;
        err_d   = !addr_ok;
        if (addr_ok) begin
          wr_cnt_d = wr_cnt_q + 16'd1;
        end
      end

      ACK: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Registers
  // -------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge value of the others, independent of statement order.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      held_addr_q <= '0;
      held_data_q <= '0;
      gnt_q       <= '0;
      ack_q       <= '0;
      err_q       <= 1'b0;
      wr_cnt_q    <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      held_addr_q <= held_addr_d;
      held_data_q <= held_data_d;
      gnt_q       <= gnt_d;
      ack_q       <= ack_d;
      err_q       <= err_d;
      wr_cnt_q    <= wr_cnt_d;
    end
  end

  // NOTE: the bank is a handful of flops that must read back as zero after
  // reset, so it is reset like any other register rather than left as RAM.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int r = 0; r < NUM_REGS; r++) begin
        bank_q[r] <= '0;
      end
    end else begin
      for (int r = 0; r < NUM_REGS; r++) begin
        bank_q[r] <= bank_d[r];
      end
    end
  end

  // -------------------------------------------------------------------------
  // Read port: decoded mux, unmatched addresses read as zero.
  // -------------------------------------------------------------------------
  always_comb begin
    rd_data_o = '0;
    for (int r = 0; r < NUM_REGS; r++) begin
      if (rd_addr_i == addr_t'(r)) begin
        rd_data_o = bank_q[r];
      end
    end
  end

  assign gnt_o    = gnt_q;
  assign ack_o    = ack_q;
  assign err_o    = err_q;
  assign busy_o   = (state_q != IDLE);
  assign wr_cnt_o = wr_cnt_q;

endmodule

// File: tb/tb_regbank_wr_arbiter.sv
// ---------------------------------------------------------------------------
// tb_regbank_wr_arbiter
//
// Directed bench for regbank_wr_arbiter. A default-parameter instance covers
// reset, single writes, round-robin rotation, pointer wrap and counter wrap;
// a NUM_REGS=3 instance covers the out-of-range address path. Inputs change
// and outputs are sampled on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_regbank_wr_arbiter;

  logic        clk = 1'b0;
  logic        rst_i;

  // Main instance (NUM_REGS = 4)
  logic [3:0]  req;
  logic [7:0]  addr;
  logic [31:0] data;
  logic [3:0]  gnt, ack;
  logic        err, busy;
  logic [1:0]  rd_addr;
  logic [7:0]  rd_data;
  logic [15:0] wr_cnt;

  // Second instance (NUM_REGS = 3)
  logic [3:0]  r3_req;
  logic [7:0]  r3_addr;
  logic [31:0] r3_data;
  logic [3:0]  r3_gnt, r3_ack;
  logic        r3_err, r3_busy;
  logic [1:0]  r3_rd_addr;
  logic [7:0]  r3_rd_data;
  logic [15:0] r3_wr_cnt;

  int n_checks = 0;
  int n_err    = 0;

  always #5 clk = ~clk;

  regbank_wr_arbiter #(.NUM_REQ(4), .SIZE(8), .NUM_REGS(4), .ADDR_W(2)) dut (
    .clk_i(clk), .rst_i(rst_i), .req_i(req), .addr_i(addr), .data_i(data),
    .gnt_o(gnt), .ack_o(ack), .err_o(err), .busy_o(busy),
    .rd_addr_i(rd_addr), .rd_data_o(rd_data), .wr_cnt_o(wr_cnt)
  );

  regbank_wr_arbiter #(.NUM_REQ(4), .SIZE(8), .NUM_REGS(3), .ADDR_W(2)) dut3 (
    .clk_i(clk), .rst_i(rst_i), .req_i(r3_req), .addr_i(r3_addr),
    .data_i(r3_data), .gnt_o(r3_gnt), .ack_o(r3_ack), .err_o(r3_err),
    .busy_o(r3_busy), .rd_addr_i(r3_rd_addr), .rd_data_o(r3_rd_data),
    .wr_cnt_o(r3_wr_cnt)
  );

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic drive(input int k, input logic [1:0] a, input logic [7:0] d);
    req[k]           = 1'b1;
    addr[k*2 +: 2]   = a;
    data[k*8 +: 8]   = d;
  endtask

  task automatic check_rd(input string tag, input logic [1:0] a,
                          input logic [7:0] exp);
    rd_addr = a;
    #1;
    check(tag, rd_data, exp);
  endtask

  // Lone request from requester k, starting and ending in IDLE.
  task automatic do_write(input string tag, input int k, input logic [1:0] a,
                          input logic [7:0] d, input logic [15:0] exp_cnt);
    logic [3:0] oh;
    oh = 4'b0001 << k;
    drive(k, a, d);
    tick();
    check({tag, "_gnt"}, gnt, oh);
    check({tag, "_busy"}, busy, 1'b1);
    tick();
    check({tag, "_ack"}, ack, oh);
    check({tag, "_gnt_low"}, gnt, 4'b0000);
    check({tag, "_err"}, err, 1'b0);
    check({tag, "_cnt"}, wr_cnt, exp_cnt);
    check_rd({tag, "_rd"}, a, d);
    req[k] = 1'b0;
    tick();
    check({tag, "_idle"}, busy, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, expected $finish");
    $fatal(1);
  end

  initial begin
    rst_i = 1'b1;
    req = '0; addr = '0; data = '0; rd_addr = '0;
    r3_req = '0; r3_addr = '0; r3_data = '0; r3_rd_addr = '0;
    tick();
    tick();
    rst_i = 1'b0;
    tick();

    // ---------------- Reset state ----------------
    check("rst_gnt", gnt, 4'b0000);
    check("rst_ack", ack, 4'b0000);
    check("rst_busy", busy, 1'b0);
    check("rst_cnt", wr_cnt, 16'd0);

    // ---------------- Reset mid-GRANT ----------------
    do_write("pre", 0, 2'd1, 8'h5A, 16'd1);
    drive(0, 2'd2, 8'hC3);
    tick();
    check("mid_gnt", gnt, 4'b0001);
    rst_i = 1'b1;
    #1;
    for (int i = 0; i < 4; i++) begin
      rd_addr = 2'(i);
      #1;
      check("mid_rst_rd", rd_data, 8'h00);
    end
    check("mid_rst_gnt", gnt, 4'b0000);
    check("mid_rst_ack", ack, 4'b0000);
    check("mid_rst_cnt", wr_cnt, 16'd0);
    check("mid_rst_busy", busy, 1'b0);
    req = '0;
    tick();
    tick();
    rst_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("dropped_no_ack", ack, 4'b0000);
    end

    // ---------------- Single write ----------------
    do_write("single", 1, 2'd3, 8'hA7, 16'd1);

    // ---------------- Round-robin fairness ----------------
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    for (int k = 0; k < 4; k++) drive(k, 2'(k), 8'h10 + 8'(k));
    for (int g = 0; g < 5; g++) begin
      tick();
      check("rr_gnt", gnt, 4'b0001 << (g % 4));
      tick();
      check("rr_ack", ack, 4'b0001 << (g % 4));
      if (g == 4) req = '0;
      tick();
      check("rr_gap", gnt, 4'b0000);
    end
    check_rd("rr_bank0", 2'd0, 8'h10);
    check_rd("rr_bank1", 2'd1, 8'h11);
    check_rd("rr_bank2", 2'd2, 8'h12);
    check_rd("rr_bank3", 2'd3, 8'h13);
    check("rr_cnt", wr_cnt, 16'd5);

    // ---------------- Pointer after wrap ----------------
    // ptr is 1 here; a lone grant to requester 2 moves it to 3.
    do_write("ptr_setup", 2, 2'd2, 8'h22, 16'd6);
    drive(0, 2'd0, 8'h30);
    drive(2, 2'd2, 8'h32);
    tick();
    check("wrap_gnt0", gnt, 4'b0001);
    tick();
    check("wrap_ack0", ack, 4'b0001);
    req[0] = 1'b0;
    tick();
    tick();
    check("wrap_gnt2", gnt, 4'b0100);
    tick();
    check("wrap_ack2", ack, 4'b0100);
    req[2] = 1'b0;
    tick();
    check_rd("wrap_bank0", 2'd0, 8'h30);
    check_rd("wrap_bank2", 2'd2, 8'h32);
    check("wrap_cnt", wr_cnt, 16'd8);

    // ---------------- Counter wrap ----------------
    // Preloading by 65535 real writes would take ~200k cycles, so the
    // counter is placed two writes short of the wrap while the block is idle.
    dut.wr_cnt_q = 16'hFFFE;
    do_write("cnt_ffff", 3, 2'd0, 8'h77, 16'hFFFF);
    do_write("cnt_wrap", 3, 2'd0, 8'h78, 16'h0000);

    // ---------------- Out-of-range address (NUM_REGS = 3) ----------------
    r3_req[1] = 1'b1; r3_addr[3:2] = 2'd2; r3_data[15:8] = 8'h33;
    tick();
    check("oor_valid_gnt", r3_gnt, 4'b0010);
    tick();
    check("oor_valid_ack", r3_ack, 4'b0010);
    check("oor_valid_err", r3_err, 1'b0);
    check("oor_valid_cnt", r3_wr_cnt, 16'd1);
    r3_req = '0;
    tick();
    r3_req[2] = 1'b1; r3_addr[5:4] = 2'd3; r3_data[23:16] = 8'hFF;
    tick();
    check("oor_gnt", r3_gnt, 4'b0100);
    tick();
    check("oor_ack", r3_ack, 4'b0100);
    check("oor_err", r3_err, 1'b1);
    check("oor_cnt", r3_wr_cnt, 16'd1);
    r3_rd_addr = 2'd3; #1;
    check("oor_rd3", r3_rd_data, 8'h00);
    r3_rd_addr = 2'd2; #1;
    check("oor_rd2", r3_rd_data, 8'h33);
    r3_rd_addr = 2'd0; #1;
    check("oor_rd0", r3_rd_data, 8'h00);
    r3_req = '0;
    tick();
    check("oor_err_clear", r3_err, 1'b0);
    check("oor_ack_clear", r3_ack, 4'b0000);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/regbank_wr_arbiter.md
Name: regbank_wr_arbiter

Overview:
- Round-robin write arbiter and sequencer for a small bank of SIZE-bit enable-gated registers, shared between NUM_REQ requesters.
- Each requester holds a request with an address and data. The block grants one requester at a time, drives the selected register's enable for exactly one cycle, and returns a one-cycle acknowledge.
- A combinational read port exposes any bank entry.
- Sits between the datapath's configuration/control masters and the shared register storage.

Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- SIZE, 8, bit width of each register
- NUM_REGS, 4, number of registers in the bank (2..16, need not be a power of two)
- ADDR_W, 2, address width; must satisfy 2**ADDR_W >= NUM_REGS

Ports:
- clk_i  in  1  clock, rising edge
- rst_i  in  1  asynchronous, active-high reset
- req_i  in  NUM_REQ  per-requester write request, level
- addr_i  in  NUM_REQ*ADDR_W  packed target addresses; requester k uses bits [k*ADDR_W +: ADDR_W]
- data_i  in  NUM_REQ*SIZE  packed write data; requester k uses bits [k*SIZE +: SIZE]
- gnt_o  out  NUM_REQ  registered one-hot grant, high for the GRANT cycle
- ack_o  out  NUM_REQ  registered one-hot acknowledge, high for the ACK cycle
- err_o  out  1  high in the ACK cycle if the acknowledged write addressed a register >= NUM_REGS
- busy_o  out  1  high whenever state != IDLE
- rd_addr_i  in  ADDR_W  read address
- rd_data_o  out  SIZE  combinational bank[rd_addr_i]; 0 if rd_addr_i >= NUM_REGS
- wr_cnt_o  out  16  count of committed writes; wraps 0xFFFF->0; excludes errored writes

Behaviour:
- Reset (rst_i high, asynchronous, any state, mid-transfer included):
  - all bank registers, gnt_o, ack_o, err_o and wr_cnt_o go to 0
  - state goes to IDLE; round-robin pointer ptr goes to 0
  - a write in flight is dropped and never acked
- FSM states and transitions:
  - IDLE: if any req_i is set, pick the winner and go to GRANT; otherwise stay in IDLE.
  - GRANT: always go to ACK.
  - ACK: always go to IDLE.
- Throughput and latency:
  - throughput is one write per 3 cycles
  - latency is req sampled at edge E0, gnt_o high after E0, bank updated and ack_o high after E1, back to IDLE after E2
- Arbitration (IDLE, at each edge):
  - The winner is the first set bit of req_i, searching upward from index ptr with wrap-around.
  - At the edge entering GRANT:
    - capture the winner's addr/data into internal holding registers
    - set gnt_o to the winner's one-hot
    - set ptr to (winner+1) mod NUM_REQ
  - ptr changes only on a grant.
  - The request vector is not resampled during GRANT or ACK; req changes there have no effect.
- Write (GRANT cycle):
  - Assert the enable of register held_addr only, with data held_data.
  - The register updates at the edge leaving GRANT.
  - If held_addr >= NUM_REGS, no register changes and err_o is set for the ACK cycle.
  - A valid write increments wr_cnt_o at the same edge.
- ACK cycle:
  - ack_o is the one-hot of the granted requester; gnt_o is 0.
  - The new value is visible on rd_data_o during ACK.
- Requester protocol:
  - Hold req/addr/data stable from assertion until ack is seen.
  - Deassert req after the edge where ack is sampled, because IDLE arbitrates at the next edge.
  - Holding req high re-requests and is granted again in round-robin turn.
- Simultaneous requests: exactly one is granted per transaction. With every requester continuously requesting, grants rotate 0,1,2,3,0,...
- rd_data_o is purely combinational and unaffected by arbitration state.
- Same-address consecutive writes: last committed wins; there is no merging.

Test Plan:
- Reset: assert rst_i mid-GRANT after writing bank[1]=0x5A -> immediately all rd_data_o reads 0, gnt_o=0, ack_o=0, wr_cnt_o=0, busy_o=0; no ack ever issued for the in-flight write.
- Single write: req_i=0010, addr1=3, data1=0xA7 -> gnt_o=0010 one cycle after, ack_o=0010 next cycle, rd_data_o(3)=0xA7 in the ACK cycle, wr_cnt_o=1, err_o=0.
- Round-robin fairness: req_i=1111 held, data_k=0x10+k to addr k -> gnt_o sequence 0001,0010,0100,1000,0001 at 3-cycle spacing; bank = {0x10,0x11,0x12,0x13}.
- Pointer after wrap: ptr=3 after grant to requester 2, then req_i=0101 -> requester 0 granted first, then requester 2.
- Out-of-range address: NUM_REGS=3, addr=3, data=0xFF -> ack_o pulses, err_o=1 in the ACK cycle, bank unchanged, wr_cnt_o unchanged, rd_data_o(3)=0.
- Counter wrap: preload by 65535 writes, then one more valid write -> wr_cnt_o goes 0xFFFF->0x0000.
